// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule expander: loads 16 words, emits W[0..ROUNDS-1].
//
// state | meaning
// ------+------------------------------------------------------------
// LOAD  | accepting message words into win[cnt], cnt counts words taken
// EMIT  | presenting W[cnt] = win[0]; each handshake slides the window
//
// Window invariant during EMIT: win[k] holds W[cnt+k].
module sha256_msg_sched #(
   parameter int ROUNDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_word,
   output logic        w_valid,
   input  logic        w_ready,
   output logic [31:0] w_data,
   output logic [5:0]  w_index,
   output logic        w_last
);

   typedef enum logic {
      LOAD = 1'b0,
      EMIT = 1'b1
   } state_t;

   localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] win_q [16];
   logic [31:0] win_d [16];
   logic [31:0] w_new;

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   // Next schedule word from the current window; carries beyond bit 31 drop.
   always_comb begin
      w_new = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
   end

   // Handshake outputs are decoded from state only, so they never depend on inputs.
   always_comb begin
      in_ready = (state_q == LOAD);
      w_valid  = (state_q == EMIT);
      w_data   = (state_q == EMIT) ? win_q[0] : 32'h0;
      w_index  = (state_q == EMIT) ? cnt_q : 6'd0;
      w_last   = (state_q == EMIT) && (cnt_q == LAST_IDX);
   end

   // Next-state, counter and window update.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      for (int i = 0; i < 16; i++) begin
         win_d[i] = win_q[i];
      end
      case (state_q)
         LOAD: begin
            if (in_valid) begin
               win_d[cnt_q[3:0]] = in_word;
               if (cnt_q == 6'd15) begin
                  state_d = EMIT;
                  cnt_d   = 6'd0;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end
         EMIT: begin
            if (w_ready) begin
               for (int i = 0; i < 15; i++) begin
                  win_d[i] = win_q[i + 1];
               end
               win_d[15] = w_new;
               if (cnt_q == LAST_IDX) begin
                  state_d = LOAD;
                  cnt_d   = 6'd0;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end
         default: begin
            state_d = LOAD;
            cnt_d   = 6'd0;
         end
      endcase
   end

   // State, counter and window registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LOAD;
         cnt_q   <= 6'd0;
         for (int i = 0; i < 16; i++) begin
            win_q[i] <= 32'h0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         for (int i = 0; i < 16; i++) begin
            win_q[i] <= win_d[i];
         end
      end
   end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed testbench for sha256_msg_sched.
module tb_sha256_msg_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_word;
   logic        w_valid;
   logic        w_ready;
   logic [31:0] w_data;
   logic [5:0]  w_index;
   logic        w_last;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] abc_blk [16];
   logic [31:0] ff_blk  [16];
   logic [31:0] cur_blk [16];
   logic [31:0] exp_w   [64];
   logic [31:0] exp_f   [64];

   sha256_msg_sched #(.ROUNDS(64)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_word  (in_word),
      .w_valid  (w_valid),
      .w_ready  (w_ready),
      .w_data   (w_data),
      .w_index  (w_index),
      .w_last   (w_last)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ms0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ms1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   task automatic build_models();
      for (int i = 0; i < 16; i++) begin
         abc_blk[i] = 32'h0;
         ff_blk[i]  = 32'hFFFFFFFF;
      end
      abc_blk[0]  = 32'h61626380;
      abc_blk[15] = 32'h00000018;
      for (int t = 0; t < 64; t++) begin
         if (t < 16) begin
            exp_w[t] = abc_blk[t];
            exp_f[t] = ff_blk[t];
         end else begin
            exp_w[t] = ms1(exp_w[t-2]) + exp_w[t-7] + ms0(exp_w[t-15]) + exp_w[t-16];
            exp_f[t] = ms1(exp_f[t-2]) + exp_f[t-7] + ms0(exp_f[t-15]) + exp_f[t-16];
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      w_ready  = 1'b0;
      in_word  = 32'h0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Offers cur_blk words; returns just after the edge that accepts the 16th.
   task automatic load_block(input bit gaps, output int n_acc);
      int guard;
      guard = 0;
      n_acc = 0;
      while (n_acc < 16 && guard < 400) begin
         @(negedge clk);
         in_word  = cur_blk[n_acc];
         in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (in_valid && in_ready) n_acc++;
         guard++;
         @(posedge clk);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_tests++; if (w_valid !== 1'b0) begin n_fail++; $display("FAIL reset_w_valid got %b want 0", w_valid); end
      n_tests++; if (w_data !== 32'h0) begin n_fail++; $display("FAIL reset_w_data got %h want 0", w_data); end
      n_tests++; if (w_index !== 6'd0) begin n_fail++; $display("FAIL reset_w_index got %0d want 0", w_index); end
      n_tests++; if (w_last !== 1'b0) begin n_fail++; $display("FAIL reset_w_last got %b want 0", w_last); end
   endtask

   task automatic test_abc();
      int n_acc, idx, guard;
      do_reset();
      cur_blk = abc_blk;
      load_block(1'b0, n_acc);
      @(negedge clk);
      in_valid = 1'b0;
      n_tests++; if (n_acc != 16) begin n_fail++; $display("FAIL abc_load_count got %0d want 16", n_acc); end
      n_tests++; if (w_valid !== 1'b1) begin n_fail++; $display("FAIL abc_latency w_valid got %b want 1", w_valid); end
      w_ready = 1'b1;
      idx = 0; guard = 0;
      while (idx < 64 && guard < 200) begin
         if (w_valid) begin
            n_tests++; if (w_index !== 6'(idx)) begin n_fail++; $display("FAIL abc_index got %0d want %0d", w_index, idx); end
            n_tests++; if (w_data !== exp_w[idx]) begin n_fail++; $display("FAIL abc_data[%0d] got %h want %h", idx, w_data, exp_w[idx]); end
            n_tests++; if (w_last !== (idx == 63)) begin n_fail++; $display("FAIL abc_last[%0d] got %b", idx, w_last); end
            if (idx == 0 || idx == 15 || idx == 16 || idx == 17 || idx == 18 || idx == 63) begin
               logic [31:0] hand;
               case (idx)
                  0:       hand = 32'h61626380;
                  15:      hand = 32'h00000018;
                  16:      hand = 32'h61626380;
                  17:      hand = 32'h000F0000;
                  18:      hand = 32'h7DA86405;
                  default: hand = 32'h12B1EDEB;
               endcase
               n_tests++; if (w_data !== hand) begin n_fail++; $display("FAIL abc_known_W%0d got %h want %h", idx, w_data, hand); end
            end
            idx++;
         end
         guard++;
         @(posedge clk);
         @(negedge clk);
      end
      n_tests++; if (idx != 64) begin n_fail++; $display("FAIL abc_timeout got %0d words want 64", idx); end
      n_tests++; if (w_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL abc_end got w_valid=%b in_ready=%b want 0/1", w_valid, in_ready); end
   endtask

   task automatic test_backpressure();
      int n_acc, idx, guard;
      bit held;
      logic [31:0] hd;
      logic [5:0] hi;
      logic hl;
      do_reset();
      cur_blk = abc_blk;
      load_block(1'b0, n_acc);
      @(negedge clk);
      in_valid = 1'b0;
      idx = 0; guard = 0; held = 1'b0; hd = '0; hi = '0; hl = 1'b0;
      while (idx < 64 && guard < 1000) begin
         w_ready = 1'($urandom_range(0, 1));
         if (held) begin
            n_tests++; if (w_valid !== 1'b1 || w_data !== hd || w_index !== hi || w_last !== hl) begin
               n_fail++; $display("FAIL bp_stable got %h/%0d/%b want %h/%0d/%b", w_data, w_index, w_last, hd, hi, hl);
            end
         end
         if (w_valid) begin
            n_tests++; if (w_index !== 6'(idx) || w_data !== exp_w[idx]) begin
               n_fail++; $display("FAIL bp_word got idx %0d data %h want idx %0d data %h", w_index, w_data, idx, exp_w[idx]);
            end
         end
         held = w_valid && !w_ready;
         hd = w_data; hi = w_index; hl = w_last;
         if (w_valid && w_ready) idx++;
         guard++;
         @(posedge clk);
         @(negedge clk);
      end
      n_tests++; if (idx != 64) begin n_fail++; $display("FAIL bp_timeout got %0d words want 64", idx); end
   endtask

   task automatic test_gaps_emit_input();
      int n_acc, idx, guard;
      do_reset();
      cur_blk = abc_blk;
      load_block(1'b1, n_acc);
      @(negedge clk);
      in_valid = 1'b1;
      in_word  = 32'hBADC0FFE;
      n_tests++; if (n_acc != 16) begin n_fail++; $display("FAIL gaps_load_count got %0d want 16", n_acc); end
      n_tests++; if (w_valid !== 1'b1) begin n_fail++; $display("FAIL gaps_latency w_valid got %b want 1", w_valid); end
      w_ready = 1'b1;
      idx = 0; guard = 0;
      while (idx < 64 && guard < 200) begin
         if (w_valid) begin
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL gaps_in_ready[%0d] got %b want 0", idx, in_ready); end
            n_tests++; if (w_index !== 6'(idx) || w_data !== exp_w[idx]) begin
               n_fail++; $display("FAIL gaps_word got idx %0d data %h want idx %0d data %h", w_index, w_data, idx, exp_w[idx]);
            end
            idx++;
         end
         guard++;
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      n_tests++; if (idx != 64) begin n_fail++; $display("FAIL gaps_timeout got %0d words want 64", idx); end
   endtask

   task automatic test_back_to_back();
      int n_acc, idx, guard, total;
      do_reset();
      w_ready = 1'b1;
      total = 0;
      for (int b = 0; b < 2; b++) begin
         cur_blk = (b == 0) ? abc_blk : ff_blk;
         load_block(1'b0, n_acc);
         @(negedge clk);
         in_valid = 1'b0;
         idx = 0; guard = 0;
         while (idx < 64 && guard < 200) begin
            if (w_valid) begin
               logic [31:0] want;
               want = (b == 0) ? exp_w[idx] : exp_f[idx];
               n_tests++; if (w_index !== 6'(idx) || w_data !== want) begin
                  n_fail++; $display("FAIL b2b_blk%0d got idx %0d data %h want idx %0d data %h", b, w_index, w_data, idx, want);
               end
               if (b == 1 && idx < 16) begin
                  n_tests++; if (w_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL b2b_ff_W%0d got %h want ffffffff", idx, w_data); end
               end
               idx++;
               total++;
            end
            guard++;
            @(posedge clk);
            @(negedge clk);
         end
         n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_after_last blk%0d got %b want 1", b, in_ready); end
      end
      n_tests++; if (total != 128) begin n_fail++; $display("FAIL b2b_total got %0d want 128", total); end
   endtask

   task automatic test_reset_mid_load();
      int n_acc, idx, guard;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_word  = 32'hDEADBEEF;
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b1;
      n_tests++; if (w_valid !== 1'b0) begin n_fail++; $display("FAIL rml_during got w_valid %b want 0", w_valid); end
      @(negedge clk);
      reset = 1'b0;
      n_tests++; if (w_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rml_after got w_valid=%b in_ready=%b want 0/1", w_valid, in_ready); end
      cur_blk = abc_blk;
      load_block(1'b0, n_acc);
      @(negedge clk);
      in_valid = 1'b0;
      n_tests++; if (w_valid !== 1'b1) begin n_fail++; $display("FAIL rml_latency w_valid got %b want 1", w_valid); end
      w_ready = 1'b1;
      idx = 0; guard = 0;
      while (idx < 64 && guard < 200) begin
         if (w_valid) begin
            n_tests++; if (w_index !== 6'(idx) || w_data !== exp_w[idx]) begin
               n_fail++; $display("FAIL rml_word got idx %0d data %h want idx %0d data %h", w_index, w_data, idx, exp_w[idx]);
            end
            idx++;
         end
         guard++;
         @(posedge clk);
         @(negedge clk);
      end
      n_tests++; if (idx != 64) begin n_fail++; $display("FAIL rml_timeout got %0d words want 64", idx); end
   endtask

   task automatic test_reset_mid_emit();
      int n_acc, guard;
      do_reset();
      cur_blk = abc_blk;
      load_block(1'b0, n_acc);
      @(negedge clk);
      in_valid = 1'b0;
      w_ready  = 1'b1;
      guard = 0;
      while (!(w_valid && w_index == 6'd30) && guard < 200) begin
         guard++;
         @(posedge clk);
         @(negedge clk);
      end
      n_tests++; if (w_data !== exp_w[30] || w_index !== 6'd30) begin
         n_fail++; $display("FAIL rme_reach got idx %0d data %h want idx 30 data %h", w_index, w_data, exp_w[30]);
      end
      reset   = 1'b1;
      w_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      n_tests++; if (w_valid !== 1'b0) begin n_fail++; $display("FAIL rme_w_valid got %b want 0", w_valid); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rme_in_ready got %b want 1", in_ready); end
      n_tests++; if (w_index !== 6'd0) begin n_fail++; $display("FAIL rme_w_index got %0d want 0", w_index); end
      n_tests++; if (w_data !== 32'h0) begin n_fail++; $display("FAIL rme_w_data got %h want 0", w_data); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_tests++; if (w_valid !== 1'b0) begin n_fail++; $display("FAIL rme_idle[%0d] got w_valid %b want 0", i, w_valid); end
      end
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_word  = 32'h0;
      w_ready  = 1'b0;
      build_models();
      test_reset();
      test_abc();
      test_backpressure();
      test_gaps_emit_input();
      test_back_to_back();
      test_reset_mid_load();
      test_reset_mid_emit();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
- SHA-256 message-schedule expander.
- Accepts one 512-bit message block as 16 serial 32-bit words.
- Emits the schedule words W[0..ROUNDS-1], one per handshake, to the compression-round stage.
- Internally uses the right-rotate network for sigma0/sigma1; it sits directly upstream of the rounds datapath.

Parameters:
- ROUNDS, 64, number of schedule words emitted per block. Legal range 16..64; the default is the only value used in production.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_word is valid this cycle.
- in_ready  out  1  block can accept a message word.
- in_word  in  32  message word; big-endian word order, W[0] first.
- w_valid  out  1  w_data/w_index are valid.
- w_ready  in  1  consumer accepts the current schedule word.
- w_data  out  32  schedule word W[w_index].
- w_index  out  6  round index t of w_data.
- w_last  out  1  high with w_valid when w_index == ROUNDS-1.

Behaviour:
- State machine states: LOAD and EMIT. A 16-entry x 32-bit window register win[0..15] holds the words, plus a 6-bit counter cnt.
- Reset (synchronous, sampled at clk edge):
  - state=LOAD, cnt=0, win[*]=0.
  - Outputs after the reset edge: in_ready=1, w_valid=0, w_data=0, w_index=0, w_last=0.
- LOAD:
  - in_ready=1, w_valid=0.
  - On in_valid&in_ready: win[cnt] <= in_word, cnt <= cnt+1.
  - On acceptance of the 16th word (cnt==15): state <= EMIT, cnt <= 0.
  - w_valid rises the cycle after the 16th word is accepted; load-to-first-output latency is 1 cycle.
- EMIT:
  - in_ready=0. in_valid is ignored and no word is consumed.
  - w_valid=1, w_data=win[0], w_index=cnt, w_last=(cnt==ROUNDS-1).
  - On w_valid&w_ready: win shifts down (win[i] <= win[i+1]), cnt <= cnt+1, and win[15] <= new, where new = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], all additions mod 2^32 with carries discarded.
  - This holds the invariant win[k]=W[cnt+k]. W[0..15] therefore emerge unchanged and W[16..] are computed.
- Sigma functions (ROTR = 32-bit rotate right, SHR = logical shift right, zero fill):
  - sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- Backpressure: while w_valid&!w_ready, w_data, w_index, w_last and win are held stable.
- End of block: on the handshake with w_last=1, state <= LOAD, cnt <= 0. in_ready=1 in the very next cycle, so there are no dead cycles between blocks.
  - Extra words computed beyond W[ROUNDS-1] are never emitted. The window is overwritten by the next load.
- Reset mid-operation, in LOAD or EMIT: the partial block is discarded and no further w_valid occurs until 16 new words are loaded.
- in_valid held high across the LOAD->EMIT boundary: only 16 words are consumed. The 17th is not accepted until the next LOAD.
- Timing: one 32-bit 4-operand adder and two sigma networks per cycle, combinational from win to the win[15] register input.

Test Plan:
- "abc" padded block:
  - Stimulus: 0x61626380, then 14 words of 0x00000000, then 0x00000018.
  - Required: w_data sequence W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W63=0x12B1EDEB.
  - w_last high only at w_index=63.
- Backpressure: same block with w_ready toggling pseudo-randomly.
  - Required: identical 64-word sequence, no skipped or duplicated index, and outputs stable while w_ready=0.
- Input gaps and EMIT-time input:
  - Stimulus: in_valid deasserted on random cycles during load, and in_valid held high throughout EMIT.
  - Required: exactly 16 words consumed per block, first w_valid exactly 1 cycle after the 16th accept, and in_ready=0 throughout EMIT.
- Back-to-back blocks: stream the "abc" block, then an all-0xFFFFFFFF block, with w_ready=1.
  - Required: in_ready=1 the cycle after w_last, 128 outputs total, second block's W0..W15=0xFFFFFFFF.
- Reset mid-load: load 8 words of 0xDEADBEEF, assert reset 1 cycle, then load the "abc" block.
  - Required: output matches the "abc" sequence exactly and w_valid=0 during and right after reset.
- Reset mid-emit: assert reset at w_index=30.
  - Required: next cycle w_valid=0, in_ready=1, w_index=0, w_data=0.
